commit_unit: RTL

In-order retirement stage of the out-of-order MIPS core. Each cycle it scans up to `COMMIT_WINDOW_SIZE` active-list entries starting at the oldest instruction. It retires the longest ready prefix and drives the commit output bundle consumed by the data-structure update stage. It owns the oldest-instruction, load, store and branch commit pointers, serialises committed stores to the D-cache through a req/ack handshake, and keeps a retired-instruction counter.

---
 rtl/commit_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement of up to W active-list entries per cycle.
// Owns the commit pointers, the retired count and the D-cache store handshake.
module commit_unit #(
  parameter int ACTIVE_LIST_SIZE   = 32,
  parameter int COMMIT_WINDOW_SIZE = 4,
  parameter int LOAD_STORE_SIZE    = 16,
  parameter int BRANCH_NUM         = 8,
  localparam int AW = $clog2(ACTIVE_LIST_SIZE),
  localparam int IW = $clog2(COMMIT_WINDOW_SIZE),
  localparam int LW = $clog2(LOAD_STORE_SIZE),
  localparam int BW = $clog2(BRANCH_NUM),
  localparam int W  = COMMIT_WINDOW_SIZE,
  localparam int AL = ACTIVE_LIST_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AL-1:0] entry_available_bit,
  input  logic [AL-1:0] ready_to_commit,
  input  logic [AL-1:0] is_load,
  input  logic [AL-1:0] is_store,
  input  logic [AL-1:0] is_branch,
  input  logic          branch_miss,
  input  logic          store_ack,
  output logic          commit_valid,
  output logic [IW-1:0] last_valid_commit_idx,
  output logic [W-1:0]  load_valid,
  output logic [W-1:0]  store_valid,
  output logic [W-1:0]  branch_valid,
  output logic [AW-1:0] oldest_inst_pointer,
  output logic [LW-1:0] load_commit_pointer,
  output logic [LW-1:0] store_commit_pointer,
  output logic [BW-1:0] branch_read_pointer,
  output logic          store_req,
  output logic [LW-1:0] store_req_index,
  output logic [31:0]   committed_count
);

  localparam int CW = IW + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_oldest;
  logic [LW-1:0] r_ld_ptr;
  logic [LW-1:0] r_st_ptr;
  logic [BW-1:0] r_br_ptr;
  logic          r_store_req;
  logic [LW-1:0] r_store_idx;
  logic [31:0]   r_count;

  logic          w_enable;
  logic [W-1:0]  w_retire;
  logic [W-1:0]  w_ld;
  logic [W-1:0]  w_st;
  logic [W-1:0]  w_br;
  logic [CW-1:0] w_n;
  logic [CW-1:0] w_nld;
  logic [CW-1:0] w_nst;
  logic [CW-1:0] w_nbr;

  // Next-state: a miss always lands in FLUSH; FLUSH lasts one quiet cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:   if (branch_miss) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = branch_miss ? ST_FLUSH : ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  assign w_enable = !rst && (r_state == ST_RUN) && !branch_miss;

  // Window scan: longest ready prefix, at most one store and only when idle.
  always_comb begin : p_window
    logic          v_alive;
    logic          v_st_seen;
    logic          v_ok;
    logic [AW-1:0] v_idx;
    w_retire  = '0;
    w_ld      = '0;
    w_st      = '0;
    w_br      = '0;
    v_alive   = w_enable;
    v_st_seen = 1'b0;
    for (int k = 0; k < W; k++) begin
      v_idx = r_oldest + AW'(k);
      v_ok  = !entry_available_bit[v_idx] && ready_to_commit[v_idx];
      if (is_store[v_idx] && (r_store_req || v_st_seen))
        v_ok = 1'b0;
      v_alive     = v_alive && v_ok;
      w_retire[k] = v_alive;
      w_ld[k]     = v_alive && is_load[v_idx];
      w_st[k]     = v_alive && is_store[v_idx];
      w_br[k]     = v_alive && is_branch[v_idx];
      if (w_st[k])
        v_st_seen = 1'b1;
    end
  end

  // Population counts of the retiring slots per class.
  always_comb begin
    w_n   = '0;
    w_nld = '0;
    w_nst = '0;
    w_nbr = '0;
    for (int k = 0; k < W; k++) begin
      w_n   = w_n   + CW'(w_retire[k]);
      w_nld = w_nld + CW'(w_ld[k]);
      w_nst = w_nst + CW'(w_st[k]);
      w_nbr = w_nbr + CW'(w_br[k]);
    end
  end

  // State register and commit pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_oldest <= '0;
      r_ld_ptr <= '0;
      r_st_ptr <= '0;
      r_br_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_oldest <= r_oldest + AW'(w_n);
      r_ld_ptr <= r_ld_ptr + LW'(w_nld);
      r_st_ptr <= r_st_ptr + LW'(w_nst);
      r_br_ptr <= r_br_ptr + BW'(w_nbr);
      r_count  <= r_count + 32'(w_n);
    end
  end

  // D-cache store handshake; survives flushes since the store is committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_store_req <= 1'b0;
      r_store_idx <= '0;
    end else if (|w_st) begin
      r_store_req <= 1'b1;
      r_store_idx <= r_st_ptr;
    end else if (r_store_req && store_ack) begin
      r_store_req <= 1'b0;
    end
  end

  assign commit_valid          = |w_retire;
  assign last_valid_commit_idx = commit_valid ? IW'(w_n - CW'(1)) : '0;
  assign load_valid            = w_ld;
  assign store_valid           = w_st;
  assign branch_valid          = w_br;
  assign oldest_inst_pointer   = r_oldest;
  assign load_commit_pointer   = r_ld_ptr;
  assign store_commit_pointer  = r_st_ptr;
  assign branch_read_pointer   = r_br_ptr;
  assign store_req             = r_store_req;
  assign store_req_index       = r_store_idx;
  assign committed_count       = r_count;

endmodule
